// File: rtl/ir_frame_tx_pkg.sv
// Shared types and constants for the IR frame transmitter: payload type, framing
// constants, serial CRC-8 step and transmitter state encoding.
package ir_frame_tx_pkg;

    typedef logic [31:0] data_t;

    localparam logic [7:0] IR_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] IR_CRC_POLY  = 8'h07;

    typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, CRC, GAP} tx_state_t;

    // One bit of MSB-first CRC-8, init 0, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? IR_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ir_carrier_mod.sv
// Carrier generator: while enabled, toggles every CARRIER_HALF cycles starting high.
// Phase restarts on enable rise or on an explicit restart strobe.
module ir_carrier_mod #(
    parameter int CARRIER_HALF = 977
) (
    input  logic clk_pixel_in,
    input  logic rst_in,
    input  logic en,
    input  logic restart,
    output logic mod_out
);
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_cur;
    logic          phase_q, phase_cur, en_q, start;

    // Restart takes effect in the same cycle so the first mark cycle is already high.
    assign start     = en & (restart | ~en_q);
    assign cnt_cur   = start ? '0 : cnt_q;
    assign phase_cur = start ? 1'b1 : phase_q;
    assign mod_out   = en & phase_cur;

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            en_q <= en;
            if (!en) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (cnt_cur == CW'(CARRIER_HALF - 1)) begin
                cnt_q   <= '0;
                phase_q <= ~phase_cur;
            end else begin
                cnt_q   <= cnt_cur + 1'b1;
                phase_q <= phase_cur;
            end
        end
    end

endmodule

// File: rtl/ir_frame_tx.sv
// IR frame transmitter: sync byte, MSB-first payload and CRC-8, Manchester coded
// on a modulated carrier, with a one-entry newest-wins pending buffer.
module ir_frame_tx
    import ir_frame_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BIT_PERIOD   = 2970,
    parameter int CARRIER_HALF = 977,
    parameter int GAP_BITS     = 4
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  ir_out,
    output logic                  busy_out,
    output logic                  frame_done_out,
    output logic                  dropped_out
);
    localparam int HALF = BIT_PERIOD / 2;
    localparam int CYW  = $clog2(BIT_PERIOD);
    localparam int MAXF = (DATA_WIDTH > GAP_BITS) ? ((DATA_WIDTH > 8) ? DATA_WIDTH : 8)
                                                  : ((GAP_BITS > 8) ? GAP_BITS : 8);
    localparam int IW   = $clog2(MAXF + 1);

    tx_state_t             state_q, state_d;
    logic [CYW-1:0]        cyc_q;
    logic [IW-1:0]         idx_q, last_idx;
    logic [DATA_WIDTH-1:0] shift_q, pend_q, load_data;
    logic [7:0]            crc_q;
    logic                  pend_vld_q, dropped_q;
    logic                  bit_end, field_end, cur_bit, first_half, frame_active;
    logic                  mark, mark_start, load;

    always_comb begin
        last_idx = '0;
        cur_bit  = 1'b0;
        case (state_q)
            SYNC: begin
                last_idx = IW'(7);
                cur_bit  = IR_SYNC_BYTE[3'd7 - idx_q[2:0]];
            end
            PAYLOAD: begin
                last_idx = IW'(DATA_WIDTH - 1);
                cur_bit  = shift_q[DATA_WIDTH-1];
            end
            CRC: begin
                last_idx = IW'(7);
                cur_bit  = crc_q[3'd7 - idx_q[2:0]];
            end
            GAP:     last_idx = IW'(GAP_BITS - 1);
            default: last_idx = '0;
        endcase
    end

    assign bit_end      = (cyc_q == CYW'(BIT_PERIOD - 1));
    assign field_end    = bit_end && (idx_q == last_idx);
    assign frame_active = (state_q == SYNC) || (state_q == PAYLOAD) || (state_q == CRC);
    assign first_half   = (cyc_q < CYW'(HALF));
    // Manchester: a 1 marks the first half, a 0 marks the second half.
    assign mark         = frame_active && (cur_bit == first_half);
    assign mark_start   = mark && ((cyc_q == '0) || (cyc_q == CYW'(HALF)));

    assign busy_out       = (state_q != IDLE);
    assign frame_done_out = (state_q == GAP) && field_end;
    assign dropped_out    = dropped_q;

    assign load      = ((state_q == IDLE) && data_in_valid)
                     || (frame_done_out && (data_in_valid || pend_vld_q));
    assign load_data = data_in_valid ? data_in : pend_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_in_valid) state_d = SYNC;
            SYNC:    if (field_end) state_d = PAYLOAD;
            PAYLOAD: if (field_end) state_d = CRC;
            CRC:     if (field_end) state_d = GAP;
            GAP:     if (field_end) state_d = (data_in_valid || pend_vld_q) ? SYNC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            cyc_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            crc_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            dropped_q <= 1'b0;
            if (load) begin
                shift_q <= load_data;
                crc_q   <= '0;
                cyc_q   <= '0;
                idx_q   <= '0;
            end else if (busy_out) begin
                cyc_q <= bit_end ? '0 : cyc_q + 1'b1;
                if (bit_end) idx_q <= field_end ? '0 : idx_q + 1'b1;
                if (bit_end && state_q == PAYLOAD) begin
                    shift_q <= shift_q << 1;
                    crc_q   <= crc8_step(crc_q, shift_q[DATA_WIDTH-1]);
                end
            end

            // The pending slot is consumed or superseded at every frame end.
            if (frame_done_out) begin
                pend_vld_q <= 1'b0;
                dropped_q  <= data_in_valid && pend_vld_q;
            end else if (busy_out && data_in_valid) begin
                pend_q     <= data_in;
                pend_vld_q <= 1'b1;
                dropped_q  <= pend_vld_q;
            end
        end
    end

    ir_carrier_mod #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
        .clk_pixel_in (clk_pixel_in),
        .rst_in       (rst_in),
        .en           (mark),
        .restart      (mark_start),
        .mod_out      (ir_out)
    );

endmodule

// File: tb/tb_ir_frame_tx.sv
// Bench for ir_frame_tx: a negedge monitor decodes every frame from ir_out and checks it
// against a scoreboard of expected payload/CRC pairs pushed when stimulus is driven.
module tb_ir_frame_tx;
    localparam int DW = 8, BP = 8, CH = 1, GB = 2;
    localparam int FRAME_CYC = (16 + DW + GB) * BP;

    logic          clk_pixel_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          ir_out, busy_out, frame_done_out, dropped_out;

    ir_frame_tx #(.DATA_WIDTH(DW), .BIT_PERIOD(BP), .CARRIER_HALF(CH), .GAP_BITS(GB)) dut (
        .clk_pixel_in   (clk_pixel_in),
        .rst_in         (rst_in),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .ir_out         (ir_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .dropped_out    (dropped_out)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    int n_vec = 0, n_err = 0;
    int frame_cnt = 0, drop_cnt = 0, b2b_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-at-a-time CRC-8 (poly 0x07, init 0).
    function automatic logic [7:0] crc_ref(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // Frame monitor / decoder
    logic       samples [FRAME_CYC];
    logic       in_frame = 1'b0, just_ended = 1'b0;
    int         pos = 0, code_err, gap_err;
    logic [23:0] bits;
    logic [3:0] h1, h2;
    logic [15:0] exp_item;

    always @(negedge clk_pixel_in) begin
        if (rst_in) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (busy_out) begin
                in_frame = 1'b1;
                pos = 0;
                if (just_ended) b2b_cnt++;
            end else begin
                chk("idle_ir", ir_out, 0);
                chk("idle_done", frame_done_out, 0);
            end
        end
        just_ended = 1'b0;
        if (in_frame && !rst_in) begin
            samples[pos] = ir_out;
            chk("busy_in_frame", busy_out, 1);
            chk("done_position", frame_done_out, (pos == FRAME_CYC - 1));
            if (pos == FRAME_CYC - 1) begin
                code_err = 0;
                gap_err  = 0;
                for (int i = 0; i < 24; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        h1[3-j] = samples[8*i + j];
                        h2[3-j] = samples[8*i + 4 + j];
                    end
                    if (h1 == 4'b1010 && h2 == 4'b0000)      bits[23-i] = 1'b1;
                    else if (h1 == 4'b0000 && h2 == 4'b1010) bits[23-i] = 1'b0;
                    else begin
                        bits[23-i] = 1'bx;
                        code_err++;
                    end
                end
                for (int k = 24 * BP; k < FRAME_CYC; k++) if (samples[k] !== 1'b0) gap_err++;
                chk("manchester_coding", code_err, 0);
                chk("gap_space", gap_err, 0);
                chk("sync_byte", bits[23:16], 8'hA5);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("payload", bits[15:8], exp_item[15:8]);
                    chk("crc", bits[7:0], exp_item[7:0]);
                end
                in_frame = 1'b0;
                just_ended = 1'b1;
                frame_cnt++;
            end else begin
                pos++;
            end
        end
    end

    always @(negedge clk_pixel_in) if (!rst_in && dropped_out === 1'b1) drop_cnt++;

    task automatic send(input logic [7:0] d, input bit expect_frame);
        @(negedge clk_pixel_in);
        data_in = d;
        data_in_valid = 1'b1;
        if (expect_frame) exp_q.push_back({d, crc_ref(d)});
        @(negedge clk_pixel_in);
        data_in_valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frame_cnt < n && k < budget) begin
            @(posedge clk_pixel_in);
            #2;
            k++;
        end
        chk("frame_wait_timeout", (frame_cnt >= n), 1);
    endtask

    int d0, b0, k;

    initial begin
        repeat (3) @(posedge clk_pixel_in);
        #1;
        chk("rst_ir", ir_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", frame_done_out, 0);
        chk("rst_dropped", dropped_out, 0);
        rst_in = 1'b0;

        // Quiet link after reset
        repeat (500) @(posedge clk_pixel_in);
        #2;
        chk("quiet_frames", frame_cnt, 0);
        chk("quiet_drops", drop_cnt, 0);

        // Single frame, then busy drops
        send(8'h01, 1);
        wait_frames(1, 400);
        chk("busy_after_frame", busy_out, 0);

        // CRC corner payloads
        send(8'hFF, 1);
        wait_frames(2, 400);
        send(8'h00, 1);
        wait_frames(3, 400);
        chk("busy_after_00", busy_out, 0);

        // Overwrite of pending, back-to-back reload
        d0 = drop_cnt;
        b0 = b2b_cnt;
        send(8'h11, 1);
        repeat (30) @(posedge clk_pixel_in);
        send(8'h22, 0);
        repeat (30) @(posedge clk_pixel_in);
        send(8'h33, 1);
        wait_frames(5, 700);
        chk("drop_overwrite", drop_cnt, d0 + 1);
        chk("back_to_back", b2b_cnt, b0 + 1);
        chk("busy_after_pair", busy_out, 0);

        // New data on the frame_done cycle beats the pending entry
        d0 = drop_cnt;
        b0 = b2b_cnt;
        send(8'h55, 1);
        repeat (40) @(posedge clk_pixel_in);
        send(8'h22, 0);
        k = 0;
        @(negedge clk_pixel_in);
        while (frame_done_out !== 1'b1 && k < 400) begin
            @(negedge clk_pixel_in);
            k++;
        end
        chk("done_wait_timeout", frame_done_out, 1);
        data_in = 8'h44;
        data_in_valid = 1'b1;
        exp_q.push_back({8'h44, crc_ref(8'h44)});
        @(negedge clk_pixel_in);
        data_in_valid = 1'b0;
        wait_frames(7, 400);
        chk("drop_at_done", drop_cnt, d0 + 1);
        chk("reload_at_done", b2b_cnt, b0 + 1);
        repeat (300) @(posedge clk_pixel_in);
        #2;
        chk("no_extra_frames", frame_cnt, 7);
        chk("scoreboard_empty", exp_q.size(), 0);

        // Reset mid-payload with pending data
        d0 = drop_cnt;
        send(8'h66, 1);
        repeat (100) @(posedge clk_pixel_in);
        send(8'h77, 0);
        @(posedge clk_pixel_in);
        #1 rst_in = 1'b1;
        @(posedge clk_pixel_in);
        #1;
        chk("abort_ir", ir_out, 0);
        chk("abort_busy", busy_out, 0);
        rst_in = 1'b0;
        exp_q.delete();
        repeat (500) @(posedge clk_pixel_in);
        #2;
        chk("no_frame_after_reset", frame_cnt, 7);
        chk("no_drop_after_reset", drop_cnt, d0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
